// File: rtl/riscvibe_pkg.sv
// Shared fetch-path types: NOP encoding, fetch status, FSM states and the
// address classifier used for both fetch requests and program-load writes.
package riscvibe_pkg;

    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

    typedef enum logic [1:0] {
        OK         = 2'd0,
        MISALIGNED = 2'd1,
        OOB        = 2'd2
    } fetch_status_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } fetch_state_t;

    // Misalignment wins over range; below-base addresses are out of range
    // even though the subtraction would wrap to a large index anyway.
    function automatic fetch_status_t classify_addr(input logic [31:0] addr,
                                                    input logic [31:0] base,
                                                    input logic [31:0] depth);
        logic [31:0] idx;
        idx = (addr - base) >> 2;
        if (addr[1:0] != 2'b00) return MISALIGNED;
        if ((addr < base) || (idx >= depth)) return OOB;
        return OK;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction word storage: one synchronous write port, one combinational
// read port. Contents power up as NOPs.
module imem_array
    import riscvibe_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter string       INIT_FILE = "",
    parameter int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem_q[i] = NOP_INSTRUCTION;
    end

    // Program-load write port; caller guarantees waddr_i is in range.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: single-outstanding request/response front end
// with programmable latency, flush, and a side program-load write port.
module instr_fetch_mem
    import riscvibe_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 1,      // 1..8
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic [1:0]  rsp_status,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
    localparam fetch_state_t FIRST_ST = (LATENCY == 1) ? ST_RESP : ST_WAIT;

    fetch_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rsp_instr_q;
    fetch_status_t rsp_status_q;

    fetch_status_t req_st, ld_st;
    logic [AW-1:0] req_idx, ld_idx;
    logic [31:0]   rd_word;
    logic          accept, mem_we;

    assign req_st  = classify_addr(req_addr, BASE_ADDR, 32'(DEPTH));
    assign ld_st   = classify_addr(ld_addr, BASE_ADDR, 32'(DEPTH));
    assign req_idx = AW'((req_addr - BASE_ADDR) >> 2);
    assign ld_idx  = AW'((ld_addr - BASE_ADDR) >> 2);
    assign accept  = req_valid && req_ready;
    // Loads are blocked during reset; only aligned in-range writes land.
    assign mem_we  = ld_en && !rst && (ld_st == OK);

    imem_array #(
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE),
        .AW        (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (ld_idx),
        .wdata_i (ld_data),
        .raddr_i (req_idx),
        .rdata_o (rd_word)
    );

    // State and latency counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: flush kills anything; WAIT counts down to RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d = FIRST_ST;
                        cnt_d   = CNT_LOAD;
                    end
                end
                ST_WAIT: begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        if (accept) begin
                            state_d = FIRST_ST;
                            cnt_d   = CNT_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Handshake outputs derived from state; flush closes the request port.
    always_comb begin
        rsp_valid = (state_q == ST_RESP);
        req_ready = !flush && ((state_q == ST_IDLE) ||
                               ((state_q == ST_RESP) && rsp_ready));
    end

    // Response capture at acceptance, so later loads cannot change it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_instr_q  <= NOP_INSTRUCTION;
            rsp_status_q <= OK;
        end else if (accept) begin
            rsp_instr_q  <= (req_st == OK) ? rd_word : NOP_INSTRUCTION;
            rsp_status_q <= req_st;
        end
    end

    assign rsp_instr  = rsp_instr_q;
    assign rsp_status = rsp_status_q;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed plus randomized bench for instr_fetch_mem over three configurations:
// d0 LATENCY=1/base 0, d1 LATENCY=3/base 0, d2 LATENCY=4/base 0x8000/DEPTH 64.
module tb_instr_fetch_mem;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst       [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic [31:0] req_addr  [3];
    logic        flush     [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_instr [3];
    logic [1:0]  rsp_status[3];
    logic        ld_en     [3];
    logic [31:0] ld_addr   [3];
    logic [31:0] ld_data   [3];

    int          LAT  [3];
    int          DEP  [3];
    logic [31:0] BASE [3];
    logic [31:0] mm   [3][1024];

    int n_cmp  = 0;
    int n_fail = 0;

    instr_fetch_mem #(.DEPTH(1024), .LATENCY(1), .BASE_ADDR(32'h0)) u_d0 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .flush(flush[0]), .rsp_valid(rsp_valid[0]),
        .rsp_ready(rsp_ready[0]), .rsp_instr(rsp_instr[0]), .rsp_status(rsp_status[0]),
        .ld_en(ld_en[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0]));

    instr_fetch_mem #(.DEPTH(1024), .LATENCY(3), .BASE_ADDR(32'h0)) u_d1 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .flush(flush[1]), .rsp_valid(rsp_valid[1]),
        .rsp_ready(rsp_ready[1]), .rsp_instr(rsp_instr[1]), .rsp_status(rsp_status[1]),
        .ld_en(ld_en[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1]));

    instr_fetch_mem #(.DEPTH(64), .LATENCY(4), .BASE_ADDR(32'h0000_8000)) u_d2 (
        .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_addr(req_addr[2]), .flush(flush[2]), .rsp_valid(rsp_valid[2]),
        .rsp_ready(rsp_ready[2]), .rsp_instr(rsp_instr[2]), .rsp_status(rsp_status[2]),
        .ld_en(ld_en[2]), .ld_addr(ld_addr[2]), .ld_data(ld_data[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference status: 0 OK, 1 misaligned, 2 out of range.
    function automatic int exp_status(input int d, input logic [31:0] a);
        if (a[1:0] != 2'b00) return 1;
        if (a < BASE[d]) return 2;
        if (((a - BASE[d]) >> 2) >= 32'(DEP[d])) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] exp_word(input int d, input logic [31:0] a);
        if (exp_status(d, a) != 0) return NOP;
        return mm[d][(a - BASE[d]) >> 2];
    endfunction

    task automatic ld(input int d, input logic [31:0] a, input logic [31:0] v);
        ld_en[d] = 1'b1; ld_addr[d] = a; ld_data[d] = v;
        tick();
        ld_en[d] = 1'b0;
        if (!rst[d] && exp_status(d, a) == 0) mm[d][(a - BASE[d]) >> 2] = v;
    endtask

    // Single fetch from idle: checks latency, data, status, hold while stalled.
    task automatic fetch(input int d, input logic [31:0] a, input int hold);
        int          lat;
        logic [31:0] ei;
        logic [31:0] es;
        ei = exp_word(d, a);
        es = 32'(exp_status(d, a));
        req_valid[d] = 1'b1; req_addr[d] = a; rsp_ready[d] = 1'b0;
        #1;
        chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
        tick();
        req_valid[d] = 1'b0;
        lat = 1;
        while (!rsp_valid[d] && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 32'(LAT[d]));
        chk("rsp_instr", rsp_instr[d], ei);
        chk("rsp_status", 32'(rsp_status[d]), es);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
            chk("hold_instr", rsp_instr[d], ei);
            chk("hold_status", 32'(rsp_status[d]), es);
            chk("hold_req_ready", 32'(req_ready[d]), 32'd0);
        end
        rsp_ready[d] = 1'b1;
        #1;
        chk("req_ready_resp", 32'(req_ready[d]), 32'd1);
        tick();
        rsp_ready[d] = 1'b0;
        chk("drain_valid", 32'(rsp_valid[d]), 32'd0);
    endtask

    initial begin
        logic [31:0] w0, w1, w2, wn, a;
        int          d, idx, seen;

        LAT[0] = 1; LAT[1] = 3; LAT[2] = 4;
        DEP[0] = 1024; DEP[1] = 1024; DEP[2] = 64;
        BASE[0] = 32'h0; BASE[1] = 32'h0; BASE[2] = 32'h0000_8000;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 1024; j++) mm[k][j] = NOP;
            rst[k] = 1'b1; req_valid[k] = 1'b0; req_addr[k] = '0; flush[k] = 1'b0;
            rsp_ready[k] = 1'b0; ld_en[k] = 1'b0; ld_addr[k] = '0; ld_data[k] = '0;
        end

        // Reset state; a load issued during reset must be dropped.
        tick();
        ld(0, 32'h20, 32'hDEAD_BEEF);
        for (int k = 0; k < 3; k++) begin
            chk("rst_valid", 32'(rsp_valid[k]), 32'd0);
            chk("rst_instr", rsp_instr[k], NOP);
            chk("rst_status", 32'(rsp_status[k]), 32'd0);
            rst[k] = 1'b0;
        end
        tick();
        for (int k = 0; k < 3; k++) chk("post_rst_ready", 32'(req_ready[k]), 32'd1);

        // Basic LATENCY=1 fetch, and the load dropped in reset.
        ld(0, 32'h10, 32'h0050_0093);
        fetch(0, 32'h10, 0);
        fetch(0, 32'h20, 0);

        // LATENCY=3 with five stalled cycles.
        ld(1, 32'h40, 32'h1234_5678);
        fetch(1, 32'h40, 5);

        // Status boundaries.
        fetch(0, 32'h12, 0);
        fetch(0, 32'h1000, 0);
        fetch(0, 32'h0FFC, 0);
        fetch(2, 32'h7FFC, 0);
        fetch(2, 32'h7FFE, 0);
        ld(2, 32'h0000_8000 + 32'd63 * 4, 32'hCAFE_0063);
        fetch(2, 32'h0000_8000 + 32'd63 * 4, 1);
        ld(2, 32'h0000_8000 + 32'd64 * 4, 32'hBAD0_0040);  // must not wrap to word 0
        fetch(2, 32'h0000_8000 + 32'd64 * 4, 0);
        fetch(2, 32'h0000_8000, 0);

        // Back-to-back stream at LATENCY=1 with a same-cycle load to word 1.
        w0 = $urandom; w1 = $urandom; w2 = $urandom; wn = $urandom;
        ld(0, 32'h0, w0); ld(0, 32'h4, w1); ld(0, 32'h8, w2);
        rsp_ready[0] = 1'b1; req_valid[0] = 1'b1; req_addr[0] = 32'h0;
        #1;
        chk("b2b_ready0", 32'(req_ready[0]), 32'd1);
        tick();
        req_addr[0] = 32'h4; ld_en[0] = 1'b1; ld_addr[0] = 32'h4; ld_data[0] = wn;
        #1;
        chk("b2b_valid0", 32'(rsp_valid[0]), 32'd1);
        chk("b2b_instr0", rsp_instr[0], w0);
        chk("b2b_ready1", 32'(req_ready[0]), 32'd1);
        tick();
        mm[0][1] = wn;
        ld_en[0] = 1'b0; req_addr[0] = 32'h8;
        #1;
        chk("b2b_valid1", 32'(rsp_valid[0]), 32'd1);
        chk("b2b_instr1_old", rsp_instr[0], w1);
        tick();
        req_valid[0] = 1'b0;
        chk("b2b_valid2", 32'(rsp_valid[0]), 32'd1);
        chk("b2b_instr2", rsp_instr[0], w2);
        tick();
        rsp_ready[0] = 1'b0;
        chk("b2b_drain", 32'(rsp_valid[0]), 32'd0);
        fetch(0, 32'h4, 0);

        // Flush at LATENCY=4 two edges after acceptance.
        ld(2, 32'h8010, 32'hAAAA_0004);
        ld(2, 32'h8014, 32'hBBBB_0005);
        req_valid[2] = 1'b1; req_addr[2] = 32'h8010;
        tick();
        req_valid[2] = 1'b0;
        tick();
        flush[2] = 1'b1; req_valid[2] = 1'b1;
        #1;
        chk("flush_blocks_req", 32'(req_ready[2]), 32'd0);
        tick();
        flush[2] = 1'b0; req_valid[2] = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid[2]) seen++;
            tick();
        end
        chk("flush_no_rsp", 32'(seen), 32'd0);
        fetch(2, 32'h8014, 0);

        // Flush in RESP overrides rsp_ready and req_valid.
        req_valid[1] = 1'b1; req_addr[1] = 32'h40;
        tick();
        req_valid[1] = 1'b0;
        tick(); tick();
        chk("pre_flush_valid", 32'(rsp_valid[1]), 32'd1);
        flush[1] = 1'b1; rsp_ready[1] = 1'b1; req_valid[1] = 1'b1; req_addr[1] = 32'h44;
        #1;
        chk("flush_resp_ready", 32'(req_ready[1]), 32'd0);
        tick();
        flush[1] = 1'b0; rsp_ready[1] = 1'b0; req_valid[1] = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid[1]) seen++;
            tick();
        end
        chk("flush_resp_dropped", 32'(seen), 32'd0);

        // Reset for one cycle mid-WAIT.
        req_valid[1] = 1'b1; req_addr[1] = 32'h40;
        tick();
        req_valid[1] = 1'b0;
        tick();
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        chk("rst_wait_valid", 32'(rsp_valid[1]), 32'd0);
        chk("rst_wait_ready", 32'(req_ready[1]), 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid[1]) seen++;
            tick();
        end
        chk("rst_wait_no_rsp", 32'(seen), 32'd0);
        fetch(1, 32'h40, 0);  // memory survives reset

        // Randomized loads and fetches against the model.
        for (int it = 0; it < 80; it++) begin
            d = $urandom_range(0, 2);
            if ($urandom_range(0, 3) == 0)
                idx = $urandom_range(DEP[d] - 2, DEP[d] + 1);
            else
                idx = $urandom_range(0, 15);
            a = BASE[d] + 32'(idx) * 4;
            if ($urandom_range(0, 4) == 0) a = a + 32'($urandom_range(1, 3));
            if (d == 2 && $urandom_range(0, 5) == 0) a = BASE[2] - 32'($urandom_range(1, 4)) * 4;
            if ($urandom_range(0, 1) == 0) ld(d, a, $urandom);
            else fetch(d, a, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
